uart_mmio: RTL and testbench

- Parametrised full-duplex UART peripheral on the shared memory-mapped IO bus. Successor to the TX-only UART.
- Adds:
  - an RX path with framing-error detection,
  - a programmable baud divisor register,
  - parametrised TX/RX FIFO depths,
  - a sticky status register,
  - a configurable base address.
- Sits beside the other IO peripherals on MADDR/MDATA/MEN/MRW/MWAIT and drives the board UART pins.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_fifo.sv | 47 ++++
 rtl/uart_mmio.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status bit positions and FSM states for the MMIO UART
package uart_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_BUSY   = 6;

  localparam logic [15:0] DIV_MIN = 16'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Divisors below DIV_MIN leave too few cycles for mid-bit RX sampling.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < DIV_MIN) ? DIV_MIN : value;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with wrap-bit pointers and a combinational head
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are irrelevant until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - full-duplex UART with TX/RX FIFOs, divisor and sticky status on the MMIO bus
module uart_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0030,
  parameter logic [15:0] DEFAULT_DIV = 16'd33,
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MADDR,
  inout  wire  [31:0] MDATA,
  input  logic        MEN,
  input  logic        MRW,
  output wire         MWAIT,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  logic        hit;
  logic        bus_wr;
  logic        bus_rd;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;
  logic [15:0] div;

  logic        tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic [7:0]  tx_head;
  uart_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;

  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  uart_state_t rx_state;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;

  logic        overrun, frame_err;
  logic        overrun_set, frame_set, overrun_clr, frame_clr;
  logic        unused_bits;

  assign hit     = MEN && (MADDR[31:4] == BASE_ADDR[31:4]);
  assign bus_wr  = hit && MRW;
  assign bus_rd  = hit && !MRW;
  assign reg_sel = MADDR[3:2];

  assign MWAIT = hit ? 1'b0 : 1'bz;
  assign MDATA = bus_rd ? rdata : 32'bz;

  assign unused_bits = &{1'b0, MADDR[1:0], MDATA[31:16]};

  assign tx_push = bus_wr && (reg_sel == REG_TXDATA);
  assign rx_pop  = bus_rd && (reg_sel == REG_RXDATA);
  assign tx_busy = (tx_state != IDLE);
  // The TX FSM takes the head both from idle and straight out of a stop bit.
  assign tx_pop  = !tx_empty && ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == 16'd0)));

  assign rx_push     = (rx_state == STOP) && (rx_cnt == 16'd0) && rx_s2;
  assign frame_set   = (rx_state == STOP) && (rx_cnt == 16'd0) && !rx_s2;
  assign overrun_set = rx_push && rx_full && !rx_pop;
  assign overrun_clr = bus_wr && (reg_sel == REG_STATUS) && MDATA[ST_OVERRUN];
  assign frame_clr   = bus_wr && (reg_sel == REG_STATUS) && MDATA[ST_FRAME_ERR];

  assign irq = !rx_empty || overrun || frame_err;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .push_data(MDATA[7:0]),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Register read mux; an empty RX FIFO reads as zero rather than a stale byte.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[ST_TX_FULL]   = tx_full;
        rdata[ST_TX_EMPTY]  = tx_empty;
        rdata[ST_RX_EMPTY]  = rx_empty;
        rdata[ST_RX_FULL]   = rx_full;
        rdata[ST_OVERRUN]   = overrun;
        rdata[ST_FRAME_ERR] = frame_err;
        rdata[ST_TX_BUSY]   = tx_busy;
      end
      REG_RXDATA: if (!rx_empty) rdata[8:0] = {1'b1, rx_head};
      REG_DIV:    rdata[15:0] = div;
      default:    rdata = '0;
    endcase
  end

  // Divisor register, clamped on write.
  always_ff @(posedge clk) begin
    if (!rst) div <= DEFAULT_DIV;
    else if (bus_wr && (reg_sel == REG_DIV)) div <= clamp_div(MDATA[15:0]);
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if (frame_set)        frame_err <= 1'b1;
      else if (frame_clr)   frame_err <= 1'b0;
    end
  end

  // TX FSM: start, 8 data bits LSB-first, stop; each bit lasts div+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (!tx_empty) begin
            tx_state <= START;
            tx_shift <= tx_head;
            tx_cnt   <= div;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else begin
            tx_state <= DATA;
            tx_cnt   <= div;
            tx_bit   <= 3'd0;
            tx       <= tx_shift[0];
          end
        end
        DATA: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else begin
            tx_cnt <= div;
            if (tx_bit == 3'd7) begin
              tx_state <= STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end
        end
        STOP: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else if (!tx_empty) begin
            tx_state <= START;
            tx_shift <= tx_head;
            tx_cnt   <= div;
            tx       <= 1'b0;
          end else begin
            tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX FSM: half-bit delay to mid-bit, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= START;
            rx_cnt   <= div >> 1;
          end
        end
        START: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else if (!rx_s2) begin
            rx_state <= DATA;
            rx_cnt   <= div;
            rx_bit   <= 3'd0;
          end else begin
            rx_state <= IDLE;
          end
        end
        DATA: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= div;
            if (rx_bit == 3'd7) rx_state <= STOP;
            else rx_bit <= rx_bit + 3'd1;
          end
        end
        STOP: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - self-checking bench for uart_mmio with a queue-based serial reference model
module tb_uart_mmio;

  localparam logic [31:0] BASE   = 32'h0000_0030;
  localparam int          DEFDIV = 33;
  localparam int          TXD    = 16;
  localparam int          RXD    = 16;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_TXDATA = 4'h4;
  localparam logic [3:0] OFF_RXDATA = 4'h8;
  localparam logic [3:0] OFF_DIV    = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] MADDR = '0;
  wire  [31:0] MDATA;
  logic        MEN = 1'b0;
  logic        MRW = 1'b0;
  wire         MWAIT;
  logic        tx;
  logic        rx;
  logic        irq;

  logic        drv_en = 1'b0;
  logic [31:0] drv_val = '0;
  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_q[$];

  assign MDATA = drv_en ? drv_val : 32'bz;
  assign rx    = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_mmio #(
    .BASE_ADDR(BASE), .DEFAULT_DIV(16'(DEFDIV)), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst(rst), .MADDR(MADDR), .MDATA(MDATA), .MEN(MEN), .MRW(MRW),
    .MWAIT(MWAIT), .tx(tx), .rx(rx), .irq(irq)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    @(negedge clk);
    MADDR = BASE + {28'd0, off}; MRW = 1'b1; MEN = 1'b1; drv_val = data; drv_en = 1'b1;
    @(posedge clk); #1;
    MEN = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    @(negedge clk);
    MADDR = BASE + {28'd0, off}; MRW = 1'b0; MEN = 1'b1;
    #1 data = MDATA;
    @(posedge clk); #1;
    MEN = 1'b0;
  endtask

  task automatic wait_tx_idle(input int bound);
    logic [31:0] st;
    int k;
    k = 0;
    st = '0;
    while (k < bound) begin
      bus_read(OFF_STATUS, st);
      if (st[1] && !st[6]) break;
      k++;
    end
    n_cmp++;
    if (!(st[1] && !st[6])) begin
      n_bad++;
      $display("FAIL tx_idle_wait: got status %h expected tx_empty=1 tx_busy=0", st);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_drv = f[i];
      repeat (div) @(negedge clk);
    end
    @(negedge clk); rx_drv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic capture_tx(input int n, input int div);
    int k;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      k = 0;
      @(posedge clk); #1;
      while (tx !== 1'b0 && k < 40 * (div + 1)) begin
        @(posedge clk); #1; k++;
      end
      if (tx !== 1'b0) return;
      repeat ((div + 1) / 2) @(posedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (div + 1) @(posedge clk);
        #1 b[j] = tx;
      end
      repeat (div + 1) @(posedge clk);
      cap_q.push_back(b);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL reset_status: got %h expected 6", d); end
    bus_read(OFF_DIV, d);
    n_cmp++; if (d !== 32'(DEFDIV)) begin n_bad++; $display("FAIL reset_div: got %h expected %h", d, DEFDIV); end
    @(negedge clk); MADDR = BASE; MRW = 1'b0; MEN = 1'b1; #1;
    n_cmp++; if (MWAIT !== 1'b0) begin n_bad++; $display("FAIL mwait_hit: got %b expected 0", MWAIT); end
    @(posedge clk); #1 MEN = 1'b0;
  endtask

  task automatic test_tx_frame;
    logic [7:0] b;
    logic [9:0] f;
    b = 8'hA5;
    f = {1'b1, b, 1'b0};
    bus_write(OFF_TXDATA, {24'd0, b});
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_write_edge: got %b expected 1", tx); end
    MADDR = BASE + 32'(OFF_STATUS); MRW = 1'b0; MEN = 1'b1;
    for (int c = 0; c < 10 * (DEFDIV + 1); c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (tx !== f[c / (DEFDIV + 1)]) begin
        n_bad++; $display("FAIL tx_bit c=%0d: got %b expected %b", c, tx, f[c / (DEFDIV + 1)]);
      end
      n_cmp++;
      if (MDATA[6] !== 1'b1) begin n_bad++; $display("FAIL tx_busy c=%0d: got %b expected 1", c, MDATA[6]); end
    end
    @(posedge clk); #1;
    n_cmp++; if (MDATA[6:0] !== 7'h06) begin n_bad++; $display("FAIL tx_done_status: got %h expected 06", MDATA[6:0]); end
    MEN = 1'b0;
  endtask

  task automatic test_loopback;
    logic [31:0] d;
    logic [7:0] vals [3];
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h55;
    loop = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(OFF_TXDATA, {24'd0, vals[i]});
    wait_tx_idle(2000);
    repeat (20) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL loop_irq_high: got %b expected 1", irq); end
    for (int i = 0; i < 3; i++) begin
      bus_read(OFF_RXDATA, d);
      n_cmp++;
      if (d !== {23'd0, 1'b1, vals[i]}) begin n_bad++; $display("FAIL loop_rx%0d: got %h expected %h", i, d, {23'd0, 1'b1, vals[i]}); end
    end
    bus_read(OFF_RXDATA, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL loop_rx_empty_read: got %h expected 0", d); end
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d[2] !== 1'b1) begin n_bad++; $display("FAIL loop_rx_empty_flag: got %b expected 1", d[2]); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL loop_irq_low: got %b expected 0", irq); end
    loop = 1'b0;
  endtask

  task automatic test_random_loopback;
    logic [31:0] d;
    logic [7:0] model_q[$];
    logic [7:0] b, e;
    int div;
    for (int round = 0; round < 2; round++) begin
      div = $urandom_range(3, 12);
      bus_write(OFF_DIV, 32'(div));
      loop = 1'b1;
      for (int i = 0; i < 6; i++) begin
        b = 8'($urandom);
        model_q.push_back(b);
        bus_write(OFF_TXDATA, {24'd0, b});
      end
      wait_tx_idle(3000);
      repeat (4 * (div + 1)) @(posedge clk);
      while (model_q.size() > 0) begin
        e = model_q.pop_front();
        bus_read(OFF_RXDATA, d);
        n_cmp++;
        if (d !== {23'd0, 1'b1, e}) begin n_bad++; $display("FAIL rand_loop div=%0d: got %h expected %h", div, d, {23'd0, 1'b1, e}); end
      end
      loop = 1'b0;
    end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] st;
    logic [7:0] sent[$];
    logic [7:0] e, g;
    int div, extra;
    div = 7;
    bus_write(OFF_DIV, 32'(div));
    cap_q.delete();
    for (int i = 0; i < TXD + 2; i++) sent.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < TXD + 2; i++) bus_write(OFF_TXDATA, {24'd0, sent[i]});
        bus_read(OFF_STATUS, st);
        n_cmp++; if (st[0] !== 1'b1) begin n_bad++; $display("FAIL ovf_tx_full: got %b expected 1", st[0]); end
      end
      capture_tx(TXD + 1, div);
    join
    // One byte is in flight while TXD wait in the FIFO; the last write has no room.
    n_cmp++;
    if (cap_q.size() != TXD + 1) begin n_bad++; $display("FAIL ovf_count: got %0d expected %0d", cap_q.size(), TXD + 1); end
    for (int i = 0; i < TXD + 1 && cap_q.size() > 0; i++) begin
      e = sent[i];
      g = cap_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL ovf_byte%0d: got %h expected %h", i, g, e); end
    end
    extra = 0;
    for (int c = 0; c < 20 * (div + 1); c++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ovf_dropped: got %0d low cycles expected 0", extra); end
    bus_read(OFF_STATUS, st);
    n_cmp++; if (st !== 32'h6) begin n_bad++; $display("FAIL ovf_status: got %h expected 6", st); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] d;
    logic [7:0] model_q[$];
    logic [7:0] b, e;
    int div;
    div = 7;
    for (int i = 0; i < RXD + 1; i++) begin
      b = 8'($urandom);
      if (i < RXD) model_q.push_back(b);
      send_frame(b, 1'b1, div);
    end
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d[3] !== 1'b1) begin n_bad++; $display("FAIL ovr_rx_full: got %b expected 1", d[3]); end
    n_cmp++; if (d[4] !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b expected 1", d[4]); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ovr_irq: got %b expected 1", irq); end
    bus_write(OFF_STATUS, 32'h10);
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d[5:4] !== 2'b00) begin n_bad++; $display("FAIL ovr_clear: got %b expected 00", d[5:4]); end
    while (model_q.size() > 0) begin
      e = model_q.pop_front();
      bus_read(OFF_RXDATA, d);
      n_cmp++;
      if (d !== {23'd0, 1'b1, e}) begin n_bad++; $display("FAIL ovr_read: got %h expected %h", d, {23'd0, 1'b1, e}); end
    end
    bus_read(OFF_RXDATA, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL ovr_drained: got %h expected 0", d); end
  endtask

  task automatic test_frame_err;
    logic [31:0] d;
    int div;
    div = 7;
    send_frame(8'($urandom), 1'b0, div);
    repeat (2 * (div + 1)) @(negedge clk);
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d[5] !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b expected 1", d[5]); end
    n_cmp++; if (d[2] !== 1'b1) begin n_bad++; $display("FAIL ferr_no_push: got %b expected 1", d[2]); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ferr_irq: got %b expected 1", irq); end
    bus_write(OFF_STATUS, 32'h20);
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (3 * (div + 1)) @(negedge clk);
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL glitch_status: got %h expected 6", d); end
  endtask

  task automatic test_div_reset;
    logic [31:0] d;
    int lows;
    bus_write(OFF_DIV, 32'd1);
    bus_read(OFF_DIV, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL div_clamp: got %h expected 3", d); end
    bus_write(OFF_TXDATA, 32'h00);
    bus_write(OFF_TXDATA, 32'h00);
    repeat (12) @(posedge clk); #1;
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL pre_reset_tx: got %b expected 0", tx); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_mid_tx: got %b expected 1", tx); end
    @(negedge clk); rst = 1'b1;
    bus_read(OFF_DIV, d);
    n_cmp++; if (d !== 32'(DEFDIV)) begin n_bad++; $display("FAIL reset_div_restore: got %h expected %h", d, DEFDIV); end
    bus_read(OFF_STATUS, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL reset_status_after: got %h expected 6", d); end
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) lows++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL reset_fifo_lost: got %0d low cycles expected 0", lows); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_random_loopback();
    test_tx_overflow();
    test_rx_overrun();
    test_frame_err();
    test_div_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
